bus_expander_fifo_port: RTL and testbench

Slave-side responder for the bus expander's fan-out: occupies four consecutive expander register slots and answers its `r_read`/`r_load` strobes. Behind those slots sit two FIFOs: an RX FIFO filled by a local producer and popped by bus reads, and a TX FIFO filled by bus writes and drained by a local consumer. Status and control registers expose fill levels and sticky error flags. It is the standard way to attach streaming peripherals (UART, SPI, sensor capture) to the expander without per-peripheral handshake glue.

---
 rtl/bus_expander_fifo_port.sv | 120 ++++++++++++
 tb/tb_bus_expander_fifo_port.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_expander_fifo_port.sv
// Expander slave exposing an RX FIFO (local producer -> bus reads) and a TX FIFO
// (bus writes -> local consumer) behind four register slots: RXDATA, TXDATA, STATUS, CONTROL.
module bus_expander_fifo_port_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          sysclk,
  input  logic          sysreset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [15:0]   wdata,
  output logic [15:0]   head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  localparam int AW = $clog2(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  // Full/empty come only from the registered count, so a full FIFO never
  // admits a push even when a pop happens in the same cycle.
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? 16'h0000 : mem[rptr];

  always_ff @(posedge sysclk)
    if (do_push && !flush) mem[wptr] <= wdata;

  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
endmodule

module bus_expander_fifo_port #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             sysclk,
  input  logic             sysreset,
  output logic [3:0][15:0] r_out,
  input  logic [3:0]       r_read,
  input  logic [3:0]       r_load,
  input  logic [15:0]      r_load_data,
  input  logic [15:0]      rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [15:0]      tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);
  generate
    if (!(DEPTH == 2 || DEPTH == 4 || DEPTH == 8 || DEPTH == 16)) begin : g_bad_depth
      $error("bus_expander_fifo_port: DEPTH must be 2, 4, 8 or 16");
    end
  endgenerate

  logic [15:0]   rx_head;
  logic [CW-1:0] rx_count, tx_count;
  logic          rx_empty, rx_full, tx_empty, tx_full;
  logic          rx_flush, tx_flush, unf_clr, ovf_clr;
  logic          rx_underflow, tx_overflow;

  assign rx_flush = r_load[3] && r_load_data[0];
  assign tx_flush = r_load[3] && r_load_data[1];
  assign unf_clr  = r_load[3] && r_load_data[2];
  assign ovf_clr  = r_load[3] && r_load_data[3];

  bus_expander_fifo_port_fifo #(.DEPTH(DEPTH), .CW(CW)) u_rx (
    .sysclk(sysclk), .sysreset(sysreset),
    .push(rx_valid), .pop(r_read[0]), .flush(rx_flush), .wdata(rx_data),
    .head(rx_head), .count(rx_count), .empty(rx_empty), .full(rx_full)
  );

  bus_expander_fifo_port_fifo #(.DEPTH(DEPTH), .CW(CW)) u_tx (
    .sysclk(sysclk), .sysreset(sysreset),
    .push(r_load[1]), .pop(tx_ready), .flush(tx_flush), .wdata(r_load_data),
    .head(tx_data), .count(tx_count), .empty(tx_empty), .full(tx_full)
  );

  assign rx_ready = !rx_full;
  assign tx_valid = !tx_empty;

  // Sticky error flags: a same-cycle set beats a clear.
  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      rx_underflow <= 1'b0;
      tx_overflow  <= 1'b0;
    end else begin
      if (r_read[0] && rx_empty) rx_underflow <= 1'b1;
      else if (unf_clr)          rx_underflow <= 1'b0;
      if (r_load[1] && tx_full)  tx_overflow  <= 1'b1;
      else if (ovf_clr)          tx_overflow  <= 1'b0;
    end
  end

  assign r_out[0] = rx_head;
  assign r_out[1] = 16'h0000;
  assign r_out[2] = {2'b00, tx_overflow, rx_underflow, tx_full, rx_empty,
                     5'(tx_count), 5'(rx_count)};
  assign r_out[3] = 16'h0000;
endmodule

// File: tb/tb_bus_expander_fifo_port.sv
// Randomized and directed bench for bus_expander_fifo_port against a queue-based model.
module tb_bus_expander_fifo_port;
  localparam int D = 16;

  logic             sysclk = 1'b0;
  logic             sysreset;
  logic [3:0][15:0] r_out;
  logic [3:0]       r_read, r_load;
  logic [15:0]      r_load_data, rx_data, tx_data;
  logic             rx_valid, rx_ready, tx_valid, tx_ready;

  logic [3:0][15:0] w_r_out;
  logic [3:0]       w_r_read, w_r_load;
  logic [15:0]      w_ld, w_rx_data, w_tx_data;
  logic             w_rx_valid, w_rx_ready, w_tx_valid, w_tx_ready;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mrx[$];
  logic [15:0] mtx[$];
  bit          m_unf, m_ovf;

  always #5 sysclk = ~sysclk;

  bus_expander_fifo_port #(.DEPTH(D)) u_dut (
    .sysclk(sysclk), .sysreset(sysreset), .r_out(r_out), .r_read(r_read),
    .r_load(r_load), .r_load_data(r_load_data), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  bus_expander_fifo_port #(.DEPTH(4)) u_dut4 (
    .sysclk(sysclk), .sysreset(sysreset), .r_out(w_r_out), .r_read(w_r_read),
    .r_load(w_r_load), .r_load_data(w_ld), .rx_data(w_rx_data),
    .rx_valid(w_rx_valid), .rx_ready(w_rx_ready), .tx_data(w_tx_data),
    .tx_valid(w_tx_valid), .tx_ready(w_tx_ready)
  );

  function automatic logic [15:0] exp_status();
    return {2'b00, m_ovf, m_unf, mtx.size() == D, mrx.size() == 0,
            5'(mtx.size()), 5'(mrx.size())};
  endfunction

  function automatic logic [15:0] exp_head();
    return (mrx.size() > 0) ? mrx[0] : 16'h0000;
  endfunction

  // Applies the spec's register/FIFO rules for the inputs seen at the edge just passed.
  task automatic model_update();
    bit rflush  = r_load[3] && r_load_data[0];
    bit tflush  = r_load[3] && r_load_data[1];
    bit unf_set = r_read[0] && mrx.size() == 0;
    bit ovf_set = r_load[1] && mtx.size() == D;
    bit rpush   = rx_valid && mrx.size() < D;
    bit rpop    = r_read[0] && mrx.size() > 0;
    bit tpush   = r_load[1] && mtx.size() < D;
    bit tpop    = tx_ready && mtx.size() > 0;
    if (!sysreset) begin
      mrx.delete(); mtx.delete(); m_unf = 0; m_ovf = 0;
      return;
    end
    if (rflush) mrx.delete();
    else begin
      if (rpop)  void'(mrx.pop_front());
      if (rpush) mrx.push_back(rx_data);
    end
    if (tflush) mtx.delete();
    else begin
      if (tpop)  void'(mtx.pop_front());
      if (tpush) mtx.push_back(r_load_data);
    end
    if (unf_set) m_unf = 1;
    else if (r_load[3] && r_load_data[2]) m_unf = 0;
    if (ovf_set) m_ovf = 1;
    else if (r_load[3] && r_load_data[3]) m_ovf = 0;
  endtask

  task automatic tick();
    @(posedge sysclk);
    model_update();
    #1;
  endtask

  task automatic idle();
    r_read = '0; r_load = '0; r_load_data = '0; rx_data = '0; rx_valid = 0; tx_ready = 0;
    w_r_read = '0; w_r_load = '0; w_ld = '0; w_rx_data = '0; w_rx_valid = 0; w_tx_ready = 0;
  endtask

  task automatic test_reset();
    sysreset = 0; idle();
    repeat (2) @(posedge sysclk);
    #1;
    n_cmp++; if (r_out[2] !== 16'h0400) begin n_bad++; $display("FAIL rst_status got %h want 0400", r_out[2]); end
    n_cmp++; if (r_out[0] !== 16'h0000) begin n_bad++; $display("FAIL rst_rxdata got %h want 0000", r_out[0]); end
    n_cmp++; if ({r_out[1], r_out[3]} !== 32'h0) begin n_bad++; $display("FAIL rst_r13 got %h want 0", {r_out[1], r_out[3]}); end
    n_cmp++; if ({rx_ready, tx_valid} !== 2'b10) begin n_bad++; $display("FAIL rst_hs got %b want 10", {rx_ready, tx_valid}); end
    n_cmp++; if (tx_data !== 16'h0000) begin n_bad++; $display("FAIL rst_txdata got %h want 0000", tx_data); end
    sysreset = 1;
    rx_valid = 1;
    for (int k = 0; k < 3; k++) begin rx_data = 16'($urandom); tick(); end
    rx_valid = 0;
    n_cmp++; if (r_out[2][4:0] !== 5'd3) begin n_bad++; $display("FAIL pre_rst_count got %0d want 3", r_out[2][4:0]); end
    #2 sysreset = 0;
    #1;
    n_cmp++; if (r_out[2] !== 16'h0400) begin n_bad++; $display("FAIL async_rst_status got %h want 0400", r_out[2]); end
    n_cmp++; if ({rx_ready, tx_valid} !== 2'b10) begin n_bad++; $display("FAIL async_rst_hs got %b want 10", {rx_ready, tx_valid}); end
    mrx.delete(); mtx.delete(); m_unf = 0; m_ovf = 0;
    @(negedge sysclk); sysreset = 1;
    tick();
  endtask

  task automatic test_rx_fill();
    rx_valid = 1;
    for (int k = 0; k < 16; k++) begin rx_data = 16'hA000 + 16'(k); tick(); end
    rx_valid = 0;
    n_cmp++; if (r_out[2][4:0] !== 5'd16) begin n_bad++; $display("FAIL rxfull_count got %0d want 16", r_out[2][4:0]); end
    n_cmp++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL rxfull_ready got %b want 0", rx_ready); end
    r_read = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (r_out[0] !== 16'hA000 + 16'(k)) begin n_bad++; $display("FAIL rx_read%0d got %h want %h", k, r_out[0], 16'hA000 + 16'(k)); end
      tick();
    end
    n_cmp++; if (r_out[0] !== 16'h0000) begin n_bad++; $display("FAIL rx_read_empty got %h want 0000", r_out[0]); end
    tick();
    r_read = '0;
    n_cmp++; if (r_out[2] !== 16'h1400) begin n_bad++; $display("FAIL rx_unf_status got %h want 1400", r_out[2]); end
    r_load = 4'b1000; r_load_data = 16'h0004; tick(); idle();
    n_cmp++; if (r_out[2] !== 16'h0400) begin n_bad++; $display("FAIL unf_clear got %h want 0400", r_out[2]); end
  endtask

  task automatic test_tx_overflow();
    tx_ready = 0; r_load = 4'b0010;
    for (int k = 1; k <= 17; k++) begin r_load_data = 16'(k); tick(); end
    idle();
    n_cmp++; if (r_out[2][9:5] !== 5'd16) begin n_bad++; $display("FAIL tx_count got %0d want 16", r_out[2][9:5]); end
    n_cmp++; if (r_out[2][13:11] !== 3'b101) begin n_bad++; $display("FAIL tx_ovf_full got %b want 101", r_out[2][13:11]); end
    tx_ready = 1;
    for (int k = 1; k <= 16; k++) begin
      n_cmp++; if ({tx_valid, tx_data} !== {1'b1, 16'(k)}) begin n_bad++; $display("FAIL tx_drain%0d got %b/%h want 1/%h", k, tx_valid, tx_data, 16'(k)); end
      tick();
    end
    n_cmp++; if ({tx_valid, tx_data} !== 17'h0) begin n_bad++; $display("FAIL tx_drained got %b/%h want 0/0000", tx_valid, tx_data); end
    tx_ready = 0; r_load = 4'b1000; r_load_data = 16'h0008; tick(); idle();
    n_cmp++; if (r_out[2] !== 16'h0400) begin n_bad++; $display("FAIL ovf_clear got %h want 0400", r_out[2]); end
  endtask

  task automatic test_wrap();
    w_rx_valid = 1; w_rx_data = 16'h0100; tick();
    for (int k = 1; k < 10; k++) begin
      w_rx_data = 16'h0100 + 16'(k); w_r_read = 4'b0001;
      n_cmp++; if (w_r_out[0] !== 16'h0100 + 16'(k - 1)) begin n_bad++; $display("FAIL wrap_pop%0d got %h want %h", k, w_r_out[0], 16'h0100 + 16'(k - 1)); end
      tick();
      n_cmp++; if (w_r_out[2][4:0] !== 5'd1) begin n_bad++; $display("FAIL wrap_count%0d got %0d want 1", k, w_r_out[2][4:0]); end
    end
    w_rx_valid = 0;
    n_cmp++; if (w_r_out[0] !== 16'h0109) begin n_bad++; $display("FAIL wrap_last got %h want 0109", w_r_out[0]); end
    tick(); idle();
    n_cmp++; if (w_r_out[2] !== 16'h0400) begin n_bad++; $display("FAIL wrap_end got %h want 0400", w_r_out[2]); end
  endtask

  task automatic test_simul();
    logic [15:0] first;
    rx_valid = 1;
    for (int k = 0; k < 2; k++) begin rx_data = 16'($urandom); tick(); end
    first = mrx[0];
    rx_data = 16'h5A5A; r_read = 4'b0001;
    n_cmp++; if (r_out[0] !== first) begin n_bad++; $display("FAIL simul_head got %h want %h", r_out[0], first); end
    tick(); idle();
    n_cmp++; if (r_out[2][4:0] !== 5'd2) begin n_bad++; $display("FAIL simul_count2 got %0d want 2", r_out[2][4:0]); end
    r_load = 4'b1000; r_load_data = 16'h0001; tick(); idle();
    n_cmp++; if (r_out[2] !== 16'h0400) begin n_bad++; $display("FAIL rx_flush got %h want 0400", r_out[2]); end
    rx_valid = 1; rx_data = 16'hBEEF; r_read = 4'b0001;
    tick(); idle();
    n_cmp++; if (r_out[2] !== 16'h1001) begin n_bad++; $display("FAIL simul_empty_status got %h want 1001", r_out[2]); end
    n_cmp++; if (r_out[0] !== 16'hBEEF) begin n_bad++; $display("FAIL simul_empty_head got %h want BEEF", r_out[0]); end
    r_load = 4'b1000; r_load_data = 16'h0005; tick(); idle();
  endtask

  task automatic test_flush_clear();
    r_load = 4'b0010;
    for (int k = 0; k < 3; k++) begin r_load_data = 16'($urandom); tick(); end
    tx_ready = 1; r_load = 4'b1000; r_load_data = 16'h0002; tick(); idle();
    n_cmp++; if ({r_out[2][9:5], tx_valid} !== 6'b0) begin n_bad++; $display("FAIL tx_flush got %0d/%b want 0/0", r_out[2][9:5], tx_valid); end
    r_load = 4'b0010;
    for (int k = 0; k < 17; k++) begin r_load_data = 16'($urandom); tick(); end
    idle();
    n_cmp++; if (r_out[2][13] !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b want 1", r_out[2][13]); end
    r_load = 4'b1000; r_load_data = 16'h0008; tick(); idle();
    n_cmp++; if (r_out[2][13] !== 1'b0) begin n_bad++; $display("FAIL ovf_clr got %b want 0", r_out[2][13]); end
    r_load = 4'b1010; r_load_data = 16'h0008; tick(); idle();
    n_cmp++; if (r_out[2][13] !== 1'b1) begin n_bad++; $display("FAIL ovf_set_wins got %b want 1", r_out[2][13]); end
    r_load = 4'b1000; r_load_data = 16'h000F; tick(); idle();
    n_cmp++; if (r_out[2] !== 16'h0400) begin n_bad++; $display("FAIL flush_all got %h want 0400", r_out[2]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rx_valid    = ($urandom_range(0, 3) != 0);
      rx_data     = 16'($urandom);
      r_read      = {3'b000, ($urandom_range(0, 2) == 0)};
      r_load      = {($urandom_range(0, 24) == 0), 1'b0, ($urandom_range(0, 1) == 0), 1'b0};
      r_load_data = 16'($urandom);
      tx_ready    = ($urandom_range(0, 2) == 0);
      n_cmp++; if (r_out[0] !== exp_head()) begin n_bad++; $display("FAIL rnd_rxdata c%0d got %h want %h", c, r_out[0], exp_head()); end
      n_cmp++; if (r_out[2] !== exp_status()) begin n_bad++; $display("FAIL rnd_status c%0d got %h want %h", c, r_out[2], exp_status()); end
      n_cmp++; if (rx_ready !== (mrx.size() < D)) begin n_bad++; $display("FAIL rnd_rx_ready c%0d got %b want %b", c, rx_ready, mrx.size() < D); end
      n_cmp++; if ({tx_valid, tx_data} !== {mtx.size() > 0, (mtx.size() > 0) ? mtx[0] : 16'h0}) begin
        n_bad++; $display("FAIL rnd_tx c%0d got %b/%h want %b/%h", c, tx_valid, tx_data, mtx.size() > 0, (mtx.size() > 0) ? mtx[0] : 16'h0);
      end
      n_cmp++; if ({r_out[1], r_out[3]} !== 32'h0) begin n_bad++; $display("FAIL rnd_r13 c%0d got %h want 0", c, {r_out[1], r_out[3]}); end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_rx_fill();
    test_tx_overflow();
    test_wrap();
    test_simul();
    test_flush_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
